cog_led_driver: RTL and testbench
=================================

Name: cog_led_driver

Overview:
- Sits downstream of the Propeller core's per-cog LED activity outputs, in the board top level.
- Per-channel behaviour:
  - Synchronises each raw activity bit into the LED clock domain.
  - Stretches short activity into a visible hold period.
  - Drives the board LED pins with PWM brightness: bright while active, dim while held.
- Replaces ad-hoc gating of the LED pins with a shared global dim signal.

Parameters:
- NUM_LEDS, 8: number of independent LED channels.
- PWM_BITS, 3: width of PWM phase counter and duty inputs.
- HOLD_CYCLES, 975: clocks an LED stays in HOLD after activity drops (50 ms at 19.5 kHz). Legal range is at least 1.
- FADE_STEP_CYCLES, 122: clocks per one-step brightness decrement in FADE. Used only with LED_FADE_EN.

Ports:
- clock, input, 1: LED/slow clock. All logic is on the rising edge.
- async_res_n, input, 1: asynchronous active-low reset. Assertion is asynchronous; release is synchronised internally by a 2-flop chain.
- led_in, input, NUM_LEDS: raw activity bits. May be asynchronous to clock.
- duty_on, input, PWM_BITS: brightness while ACTIVE. Quasi-static.
- duty_hold, input, PWM_BITS: brightness while HOLD. Quasi-static.
- led_out, output, NUM_LEDS: registered PWM LED drive.
- any_active, output, 1: registered OR of all channels not in IDLE.
- pwm_phase, output, PWM_BITS: current PWM counter, exported for sharing with other dimmed LEDs.

Behaviour:
- Reset:
  - While async_res_n=0: led_out=0, any_active=0, pwm_phase=0.
  - All channels are in IDLE; synchroniser flops and hold timers are 0.
  - Reset mid-operation aborts any ACTIVE/HOLD/FADE state immediately.
- PWM counter:
  - pwm_phase increments by 1 every clock.
  - Wraps from 2^PWM_BITS-1 to 0. No enable.
- Synchroniser: 2 flops per channel. The synced bit s[i] lags led_in[i] by 2 clocks.
- Channel FSM (per channel, independent):
  - IDLE:
    - s=1 → ACTIVE.
    - Else stay.
  - ACTIVE:
    - s=1 → stay.
    - s=0 → HOLD, with timer loaded to HOLD_CYCLES-1.
  - HOLD:
    - s=1 → ACTIVE. This has priority over timer expiry.
    - Else if timer==0 → IDLE (or FADE with LED_FADE_EN).
    - Else timer decrements by 1.
  - Timer width is clog2(HOLD_CYCLES)+1. The timer does not wrap.
- Duty select:
  - IDLE uses 0.
  - ACTIVE uses duty_on.
  - HOLD uses duty_hold.
  - Duty inputs are sampled every clock; a change applies on the next compare.
- Output:
  - led_out[i] is registered and equals (duty_sel[i] > pwm_phase), unsigned compare.
  - duty 0 → always off.
  - duty 2^PWM_BITS-1 → on for all phases except the maximum.
- Latency:
  - Count from the first clock edge that samples led_in[i]=1 with the channel in IDLE.
  - The state is ACTIVE after edge 2.
  - led_out[i] can first be 1 after edge 3, if the compare is true.
- any_active is a registered OR of (state != IDLE), with the same timing as led_out.
- Pulses on led_in shorter than one clock may be missed. This is acceptable.
- Glitches that survive the synchroniser each give at least 1 ACTIVE clock plus a full HOLD.

Optional Feature:
- Macro: LED_FADE_EN.
- With the macro:
  - Adds a FADE state and a per-channel level register of PWM_BITS width.
  - A shared prescaler counts FADE_STEP_CYCLES clocks and pulses fade_tick.
  - HOLD with timer==0 → FADE, with level = duty_hold.
  - In FADE, duty_sel = level. Each fade_tick decrements level.
  - level==0 at a fade_tick → IDLE.
  - s=1 in FADE → ACTIVE, with priority over the tick.
  - If duty_hold==0, HOLD expiry goes directly to IDLE.
  - The prescaler resets to 0 and free-runs.
- Without the macro: there is no FADE state, no level register, and no prescaler. FADE_STEP_CYCLES is ignored. HOLD expiry → IDLE.

Test Plan:
- Reset: hold async_res_n=0 with led_in=8'hFF and the clock running → led_out=0, any_active=0, pwm_phase=0 throughout. After release, pwm_phase counts 0,1,2,...,7,0.
- Active duty: PWM_BITS=3, duty_on=7, led_in[0]=1 for 40 clocks → led_out[0]=1 on 7 of every 8 clocks, 0 when the previous pwm_phase=7. First 1 is no earlier than 3 clocks after the first sample. Other bits stay 0.
- Hold: HOLD_CYCLES=4, duty_hold=1, drop led_in[0] → led_out[0]=1 only for previous phase 0, for exactly 4 HOLD clocks. Then led_out[0]=0 and any_active=0 one clock after IDLE.
- Retrigger: re-raise led_in[0] in the 2nd HOLD clock → returns to ACTIVE with duty_on brightness. The next fall reloads the timer and gives a full 4-clock HOLD.
- Async reset mid-HOLD: pulse async_res_n low between clock edges → led_out and any_active go to 0 without waiting for a clock edge. The channel is IDLE after release.
- Fade (LED_FADE_EN): duty_hold=3, FADE_STEP_CYCLES=2 → after HOLD, level goes 3,2,1,0 on successive fade_ticks, then IDLE. Raising led_in during FADE returns to ACTIVE.

Source files
------------

// File: rtl/cog_led_driver.sv
// cog_led_driver: per-cog LED activity stretcher with shared PWM dimming.
//
// Each raw activity bit is synchronised into the LED clock domain. It is then
// stretched by a per-channel IDLE/ACTIVE/HOLD state machine. The chosen
// brightness is turned into a registered PWM drive against a free-running
// phase counter.
//
// Optional feature macro: LED_FADE_EN
//   Adds a FADE state after HOLD. The brightness level steps down from
//   duty_hold once per fade_tick, until the channel returns to IDLE.
//
// Ports:
//   clock        LED clock; all logic on the rising edge
//   async_res_n  asynchronous active-low reset; release synchronised internally
//   led_in       raw per-cog activity bits (asynchronous to clock)
//   duty_on      brightness while ACTIVE (quasi-static)
//   duty_hold    brightness while HOLD (quasi-static)
//   led_out      registered PWM LED drive
//   any_active   registered OR of all channels not in IDLE
//   pwm_phase    current PWM phase counter, for sharing with other dimmed LEDs
module cog_led_driver #(
    parameter int unsigned NUM_LEDS         = 8,
    parameter int unsigned PWM_BITS         = 3,
    parameter int unsigned HOLD_CYCLES      = 975,
    parameter int unsigned FADE_STEP_CYCLES = 122
) (
    input  logic                clock,
    input  logic                async_res_n,
    input  logic [NUM_LEDS-1:0] led_in,
    input  logic [PWM_BITS-1:0] duty_on,
    input  logic [PWM_BITS-1:0] duty_hold,
    output logic [NUM_LEDS-1:0] led_out,
    output logic                any_active,
    output logic [PWM_BITS-1:0] pwm_phase
);

    localparam int unsigned TW = $clog2(HOLD_CYCLES) + 1;

    // Elaboration-time parameter legality checks
    if (HOLD_CYCLES < 1 || FADE_STEP_CYCLES < 1) begin : g_bad_param
        $error("cog_led_driver: HOLD_CYCLES and FADE_STEP_CYCLES must be >= 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_HOLD   = 2'd2
`ifdef LED_FADE_EN
        ,
        ST_FADE   = 2'd3
`endif
    } state_e;

    // Reset: assert asynchronously, release after two clock edges
    logic [1:0] rst_sync_q;
    logic       rst_n;

    always_ff @(posedge clock or negedge async_res_n) begin
        if (!async_res_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n = rst_sync_q[1];

    // Free-running PWM phase counter, wraps naturally
    logic [PWM_BITS-1:0] phase_q;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_q + PWM_BITS'(1);
        end
    end

    // Two-flop activity synchroniser; sync_q is the usable bit
    logic [NUM_LEDS-1:0] meta_q;
    logic [NUM_LEDS-1:0] sync_q;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= led_in;
            sync_q <= meta_q;
        end
    end

`ifdef LED_FADE_EN
    localparam int unsigned PSW = (FADE_STEP_CYCLES > 1) ? $clog2(FADE_STEP_CYCLES) : 1;

    // Shared fade prescaler; fade_tick pulses once every FADE_STEP_CYCLES clocks
    logic [PSW-1:0] presc_q;
    logic           fade_tick;

    assign fade_tick = (presc_q == PSW'(FADE_STEP_CYCLES - 1));

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
        end else if (fade_tick) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + PSW'(1);
        end
    end
`endif

    logic [NUM_LEDS-1:0] led_vec;
    logic [NUM_LEDS-1:0] busy_vec;

    for (genvar i = 0; i < NUM_LEDS; i++) begin : g_ch
        state_e              state_q, state_d;
        logic [TW-1:0]       timer_q, timer_d;
        logic [PWM_BITS-1:0] duty_sel;
        logic                led_q;
`ifdef LED_FADE_EN
        logic [PWM_BITS-1:0] level_q, level_d;
`endif

        // Channel state register, hold timer and registered PWM compare
        always_ff @(posedge clock or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= ST_IDLE;
                timer_q <= '0;
                led_q   <= 1'b0;
`ifdef LED_FADE_EN
                level_q <= '0;
`endif
            end else begin
                state_q <= state_d;
                timer_q <= timer_d;
                led_q   <= (duty_sel > phase_q);
`ifdef LED_FADE_EN
                level_q <= level_d;
`endif
            end
        end

        // Next-state and duty selection; fresh activity beats any expiry
        always_comb begin
            state_d  = state_q;
            timer_d  = timer_q;
            duty_sel = '0;
`ifdef LED_FADE_EN
            level_d  = level_q;
`endif
            unique case (state_q)
                ST_IDLE: begin
                    if (sync_q[i]) begin
                        state_d = ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    duty_sel = duty_on;
                    if (!sync_q[i]) begin
                        state_d = ST_HOLD;
                        timer_d = TW'(HOLD_CYCLES - 1);
                    end
                end
                ST_HOLD: begin
                    duty_sel = duty_hold;
                    if (sync_q[i]) begin
                        state_d = ST_ACTIVE;
                    end else if (timer_q == '0) begin
`ifdef LED_FADE_EN
                        // A zero hold brightness has nothing to fade from
                        if (duty_hold != '0) begin
                            state_d = ST_FADE;
                            level_d = duty_hold;
                        end else begin
                            state_d = ST_IDLE;
                        end
`else
                        state_d = ST_IDLE;
`endif
                    end else begin
                        timer_d = timer_q - TW'(1);
                    end
                end
`ifdef LED_FADE_EN
                ST_FADE: begin
                    duty_sel = level_q;
                    if (sync_q[i]) begin
                        state_d = ST_ACTIVE;
                    end else if (fade_tick) begin
                        if (level_q == '0) begin
                            state_d = ST_IDLE;
                        end else begin
                            level_d = level_q - PWM_BITS'(1);
                        end
                    end
                end
`endif
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        assign led_vec[i]  = led_q;
        assign busy_vec[i] = (state_q != ST_IDLE);
    end

    // any_active registered alongside led_out so both share the same timing
    logic any_q;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            any_q <= 1'b0;
        end else begin
            any_q <= |busy_vec;
        end
    end

    assign led_out    = led_vec;
    assign any_active = any_q;
    assign pwm_phase  = phase_q;

endmodule

// File: tb/tb_cog_led_driver.sv
// Directed table-driven bench for cog_led_driver (HOLD_CYCLES=4, FADE_STEP_CYCLES=2).
module tb_cog_led_driver;

    localparam int unsigned NL = 8;
    localparam int unsigned PB = 3;

    logic          clock = 1'b0;
    logic          async_res_n;
    logic [NL-1:0] led_in;
    logic [PB-1:0] duty_on;
    logic [PB-1:0] duty_hold;
    logic [NL-1:0] led_out;
    logic          any_active;
    logic [PB-1:0] pwm_phase;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [NL-1:0] led_in;
        logic [NL-1:0] exp_led;
        logic          exp_any;
    } vec_t;

    vec_t tbl[$];

    always #5 clock = ~clock;

    cog_led_driver #(
        .NUM_LEDS        (NL),
        .PWM_BITS        (PB),
        .HOLD_CYCLES     (4),
        .FADE_STEP_CYCLES(2)
    ) dut (
        .clock      (clock),
        .async_res_n(async_res_n),
        .led_in     (led_in),
        .duty_on    (duty_on),
        .duty_hold  (duty_hold),
        .led_out    (led_out),
        .any_active (any_active),
        .pwm_phase  (pwm_phase)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Leaves the bench at a negedge where pwm_phase==7, so the next edge makes phase 0
    task automatic align_phase7();
        logic found;
        found = 1'b0;
        for (int n = 0; n < 20 && !found; n++) begin
            @(negedge clock);
            if (pwm_phase == 3'd7) found = 1'b1;
        end
        chk("align_phase7", 32'(found), 32'd1);
    endtask

    // Record r drives led_in before edge r+1 and checks outputs after it
    task automatic run_tbl(input string name);
        for (int r = 0; r < tbl.size(); r++) begin
            led_in = tbl[r].led_in;
            @(negedge clock);
            chk($sformatf("%s_led[%0d]", name, r), 32'(led_out), 32'(tbl[r].exp_led));
            chk($sformatf("%s_any[%0d]", name, r), 32'(any_active), 32'(tbl[r].exp_any));
        end
    endtask

    task automatic wait_idle(input string name, input int budget);
        logic seen;
        seen = 1'b0;
        for (int n = 0; n < budget && !seen; n++) begin
            @(negedge clock);
            if (!any_active) seen = 1'b1;
        end
        chk(name, 32'(seen), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t v;
        int   ones;
        int   cnt;

        async_res_n = 1'b0;
        led_in      = 8'hFF;
        duty_on     = 3'd7;
        duty_hold   = 3'd1;

        // Reset held with every activity input high
        for (int n = 0; n < 6; n++) begin
            @(negedge clock);
            chk("rst_led_out", 32'(led_out), 32'd0);
            chk("rst_any", 32'(any_active), 32'd0);
            chk("rst_phase", 32'(pwm_phase), 32'd0);
        end
        async_res_n = 1'b1;
        led_in      = '0;
        @(negedge clock);
        chk("rel_phase0", 32'(pwm_phase), 32'd0);
        begin
            logic moved;
            moved = 1'b0;
            for (int n = 0; n < 6 && !moved; n++) begin
                @(negedge clock);
                if (pwm_phase != 3'd0) moved = 1'b1;
            end
            chk("rel_phase_moves", 32'(moved), 32'd1);
        end
        chk("rel_phase1", 32'(pwm_phase), 32'd1);
        for (int j = 0; j < 8; j++) begin
            @(negedge clock);
            chk("rel_phase_seq", 32'(pwm_phase), 32'((j + 2) % 8));
        end

        // Scenario 1: 38 clocks of activity on channel 0, then a full hold.
        // Edge k: state from led_in(k-2); led_out from state/phase after k-1, phase=(k-2)%8.
        tbl.delete();
        for (int k = 1; k <= 48; k++) begin
            v.led_in  = (k <= 38) ? 8'h01 : 8'h00;
            if (k >= 4 && k <= 41) v.exp_led = ((k - 2) % 8 != 7) ? 8'h01 : 8'h00;
            else if (k == 42)      v.exp_led = 8'h01;
            else                   v.exp_led = 8'h00;
            v.exp_any = (k >= 4 && k <= 45);
            tbl.push_back(v);
        end
        align_phase7();
        run_tbl("active_hold");

        // Scenario 2: retrigger in the second HOLD clock, then a full reloaded hold
        tbl.delete();
        for (int k = 1; k <= 60; k++) begin
            v.led_in  = ((k <= 38) || (k >= 43 && k <= 50)) ? 8'h01 : 8'h00;
            if (k >= 4 && k <= 41)       v.exp_led = ((k - 2) % 8 != 7) ? 8'h01 : 8'h00;
            else if (k == 42)            v.exp_led = 8'h01;
            else if (k >= 46 && k <= 53) v.exp_led = ((k - 2) % 8 != 7) ? 8'h01 : 8'h00;
            else                         v.exp_led = 8'h00;
            v.exp_any = (k >= 4 && k <= 57);
            tbl.push_back(v);
        end
        align_phase7();
        run_tbl("retrigger");

        // Scenario 3: duty_on=0 keeps an active channel dark but still busy
        duty_on = 3'd0;
        led_in  = 8'h20;
        for (int n = 0; n < 12; n++) begin
            @(negedge clock);
            chk("duty0_led_out", 32'(led_out), 32'd0);
        end
        chk("duty0_any", 32'(any_active), 32'd1);
        led_in = '0;
        wait_idle("duty0_idle", 20);
        duty_on = 3'd7;

        // Scenario 4: asynchronous reset between edges while in HOLD
        duty_hold = 3'd7;
        led_in    = 8'h01;
        repeat (10) @(negedge clock);
        led_in = '0;
        repeat (4) @(negedge clock);
        chk("pre_rst_any", 32'(any_active), 32'd1);
        @(posedge clock);
        #2;
        async_res_n = 1'b0;
        #1;
        chk("async_led_out", 32'(led_out), 32'd0);
        chk("async_any", 32'(any_active), 32'd0);
        chk("async_phase", 32'(pwm_phase), 32'd0);
        repeat (3) @(negedge clock);
        async_res_n = 1'b1;
        for (int n = 0; n < 12; n++) begin
            @(negedge clock);
            chk("post_rst_any", 32'(any_active), 32'd0);
            chk("post_rst_led", 32'(led_out), 32'd0);
        end
        duty_hold = 3'd1;

`ifdef LED_FADE_EN
        // Fade: 4 HOLD clocks, then level 3,2,1,0 on ticks every 2 clocks, then IDLE
        duty_hold = 3'd3;
        led_in    = 8'h01;
        repeat (10) @(negedge clock);
        led_in = '0;
        cnt    = 0;
        for (int n = 0; n < 40 && any_active; n++) begin
            @(negedge clock);
            if (any_active) cnt++;
        end
        chk("fade_len", 32'((cnt == 14) || (cnt == 15)), 32'd1);

        // Raise activity in the middle of FADE; must return to full brightness
        led_in = 8'h01;
        repeat (10) @(negedge clock);
        led_in = '0;
        repeat (11) @(negedge clock);
        chk("fade_busy", 32'(any_active), 32'd1);
        led_in = 8'h01;
        for (int n = 0; n < 6; n++) begin
            @(negedge clock);
            chk("fade_retrig_any", 32'(any_active), 32'd1);
        end
        ones = 0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clock);
            if (led_out[0]) ones++;
        end
        chk("fade_retrig_duty", 32'(ones), 32'd7);
        led_in = '0;
        wait_idle("fade_idle", 60);
        duty_hold = 3'd1;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
